// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: the PC sequencer state encoding,
// the default reset/trap vectors and the redirect target helpers.
package mips_pkg;

    // Fetch sequencer states; the encoding is visible on pc_control.state.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VEC   = 32'h0000_0180;

    // Conditional branch: word offset relative to the delay-slot address, mod 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                  input logic [31:0] offset);
        return pc_plus4 + (offset << 2);
    endfunction

    // J-type: 256 MB region of pc+4 concatenated with the word index.
    function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                                input logic [25:0] index);
        return {region, index, 2'b00};
    endfunction

endpackage

// File: rtl/AddFour.sv
// Combinational pc + 4 incrementer; wraps mod 2^32.
module AddFour (
    input  logic [31:0] value,
    output logic [31:0] sum
);

    assign sum = value + 32'd4;

endmodule

// File: rtl/pc_control.sv
// Program counter sequencer: IDLE -> FETCH after reset, valid/ready handshake
// to instruction memory, redirect selection and a HALTED state with resume.
// Build option: PC_MISALIGN_TRAP_EN enables the misaligned jump-register trap
// (redirect to EXC_VEC with a one-cycle misalign_trap pulse); without it the
// low two bits of jr_target are cleared and misalign_trap is tied low.
//
// Handshake: fetch_valid is high only in FETCH and depends on state alone;
// a fetch is accepted on a rising edge where fetch_valid && fetch_ready.
// pc and all redirect decisions are held/ignored until that accept.
module pc_control
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
    parameter logic [31:0] EXC_VEC   = DEFAULT_EXC_VEC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    input  logic        halt,
    input  logic        resume,
    output logic [1:0]  state,
    output logic [31:0] retire_count,
    output logic        misalign_trap
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retire_q, retire_d;
    logic        accept;

    AddFour u_add_four (
        .value (pc_q),
        .sum   (pc_plus4)
    );

    assign fetch_valid  = (state_q == ST_FETCH);
    assign accept       = fetch_valid && fetch_ready;
    assign pc           = pc_q;
    assign state        = state_q;
    assign retire_count = retire_q;

`ifdef PC_MISALIGN_TRAP_EN
    logic trap_q, trap_d;

    assign misalign_trap = trap_q;
`else
    // The low jr_target bits and EXC_VEC only matter when the trap is built in.
    logic unused_ok;

    assign misalign_trap = 1'b0;
    assign unused_ok     = &{1'b0, jr_target[1:0], EXC_VEC};
`endif

    // Next-state, next-pc and retire counter selection.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        retire_d = retire_q;
`ifdef PC_MISALIGN_TRAP_EN
        trap_d   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (accept) begin
                    retire_d = retire_q + 32'd1;
                    if (halt) begin
                        pc_d    = pc_plus4;
                        state_d = ST_HALTED;
                    end else if (jump_reg) begin
`ifdef PC_MISALIGN_TRAP_EN
                        if (jr_target[1:0] != 2'b00) begin
                            pc_d   = EXC_VEC;
                            trap_d = 1'b1;
                        end else begin
                            pc_d = jr_target;
                        end
`else
                        pc_d = {jr_target[31:2], 2'b00};
`endif
                    end else if (jump) begin
                        pc_d = jump_target(pc_plus4[31:28], jump_index);
                    end else if (branch_taken) begin
                        pc_d = branch_target(pc_plus4, branch_offset);
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pc and retire counter registers; reset abandons any pending fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_VEC;
            retire_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            retire_q <= retire_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    // One-cycle trap pulse following a misaligned jump-register accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end
`endif

endmodule

// File: tb/tb_pc_control.sv
// Directed bench for pc_control with hand-computed expected values.
module tb_pc_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid;
    logic        fetch_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_offset = 32'd0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = 26'd0;
    logic        jump_reg = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic [1:0]  state;
    logic [31:0] retire_count;
    logic        misalign_trap;

    int n_checks = 0;
    int n_pass   = 0;

    pc_control dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jump_reg      (jump_reg),
        .jr_target     (jr_target),
        .halt          (halt),
        .resume        (resume),
        .state         (state),
        .retire_count  (retire_count),
        .misalign_trap (misalign_trap)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // advance one rising edge, then settle before sampling
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        branch_taken = 1'b0; branch_offset = 32'd0;
        jump = 1'b0; jump_index = 26'd0;
        jump_reg = 1'b0; jr_target = 32'd0;
        halt = 1'b0; resume = 1'b0;
    endtask

    // one accepted fetch through jump_reg to an aligned address
    task automatic jr_to(input logic [31:0] target);
        clear_redirects();
        fetch_ready = 1'b1;
        jump_reg = 1'b1; jr_target = target;
        cyc();
        clear_redirects();
    endtask

    task automatic check_status(input string tag, input logic [31:0] exp_pc,
                                input logic [1:0] exp_state, input logic [31:0] exp_rc);
        check({tag, " pc"}, pc, exp_pc);
        check({tag, " state"}, {30'd0, state}, {30'd0, exp_state});
        check({tag, " retire"}, retire_count, exp_rc);
    endtask

    initial begin
        // reset values while rst is held
        #2;
        check("rst pc", pc, 32'h0);
        check("rst state", {30'd0, state}, 32'd0);
        check("rst valid", {31'd0, fetch_valid}, 32'd0);
        check("rst retire", retire_count, 32'd0);
        check("rst trap", {31'd0, misalign_trap}, 32'd0);
        cyc();
        rst = 1'b0;
        fetch_ready = 1'b1;
        check("idle valid", {31'd0, fetch_valid}, 32'd0);
        check("idle state", {30'd0, state}, 32'd0);

        // sequential run: 0,4,8,12
        cyc();
        check_status("seq0", 32'h0, 2'd1, 32'd0);
        check("seq0 valid", {31'd0, fetch_valid}, 32'd1);
        check("seq0 plus4", pc_plus4, 32'h4);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            check_status("seq", 32'(i * 4), 2'd1, 32'(i));
        end

        // backpressure at pc=8 with a branch request pending
        jr_to(32'h8);
        check_status("jr8", 32'h8, 2'd1, 32'd4);
        fetch_ready = 1'b0;
        branch_taken = 1'b1; branch_offset = 32'd5; jump = 1'b1; jump_index = 26'h3;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_status("stall", 32'h8, 2'd1, 32'd4);
        end
        clear_redirects();

        // priority: jump beats branch
        jr_to(32'h0000_1000);
        check_status("jr1000", 32'h0000_1000, 2'd1, 32'd5);
        jump = 1'b1; jump_index = 26'h40;
        branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFF;
        cyc();
        clear_redirects();
        check_status("jump", 32'h0000_0100, 2'd1, 32'd6);
        // branch only, offset -1 from 0x1000 loops to itself
        jr_to(32'h0000_1000);
        branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFF;
        cyc();
        clear_redirects();
        check_status("branch", 32'h0000_1000, 2'd1, 32'd8);
        // jump_reg beats jump
        jump_reg = 1'b1; jr_target = 32'h0000_0040; jump = 1'b1; jump_index = 26'h7;
        cyc();
        clear_redirects();
        check_status("jr>jump", 32'h0000_0040, 2'd1, 32'd9);

        // halt beats redirects, then resume
        jr_to(32'h20);
        halt = 1'b1; jump_reg = 1'b1; jr_target = 32'h500; jump = 1'b1;
        cyc();
        clear_redirects();
        check_status("halt", 32'h24, 2'd2, 32'd11);
        check("halt valid", {31'd0, fetch_valid}, 32'd0);
        branch_taken = 1'b1; branch_offset = 32'd9;
        cyc();
        clear_redirects();
        check_status("halted", 32'h24, 2'd2, 32'd11);
        resume = 1'b1;
        fetch_ready = 1'b0;
        cyc();
        resume = 1'b0;
        check_status("resume", 32'h24, 2'd1, 32'd11);
        fetch_ready = 1'b1;
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        check_status("resume ign", 32'h28, 2'd1, 32'd12);

        // misaligned jump register
        jump_reg = 1'b1; jr_target = 32'h0000_0102;
        cyc();
        clear_redirects();
`ifdef PC_MISALIGN_TRAP_EN
        check_status("mis", 32'h180, 2'd1, 32'd13);
        check("mis trap", {31'd0, misalign_trap}, 32'd1);
        cyc();
        check_status("mis next", 32'h184, 2'd1, 32'd14);
`else
        check_status("mis", 32'h100, 2'd1, 32'd13);
        check("mis trap", {31'd0, misalign_trap}, 32'd0);
        cyc();
        check_status("mis next", 32'h104, 2'd1, 32'd14);
`endif
        check("mis trap off", {31'd0, misalign_trap}, 32'd0);

        // pc and retire_count wrap
        jr_to(32'hFFFF_FFFC);
        check_status("top", 32'hFFFF_FFFC, 2'd1, 32'd15);
        check("top plus4", pc_plus4, 32'h0);
        cyc();
        check_status("pc wrap", 32'h0, 2'd1, 32'd16);
        fetch_ready = 1'b0;
        cyc();
        dut.retire_q = 32'hFFFF_FFFF;
        fetch_ready = 1'b1;
        cyc();
        check_status("rc wrap", 32'h4, 2'd1, 32'd0);

        // reset asserted mid-handshake
        fetch_ready = 1'b0;
        cyc();
        fetch_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_status("mid rst", 32'h0, 2'd0, 32'd0);
        check("mid rst valid", {31'd0, fetch_valid}, 32'd0);
        cyc();
        check_status("mid rst hold", 32'h0, 2'd0, 32'd0);
        rst = 1'b0;
        cyc();
        check_status("after rst", 32'h0, 2'd1, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_control.md
PC_CONTROL -- requirements
Module: pc_control

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter EXC_VEC, default 32'h0000_0180, meaning the trap redirect address.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port fetch_valid, output, 1 bit, which presents pc to instruction memory.
REQ-006 SHALL have port fetch_ready, input, 1 bit; instruction memory accepts pc this cycle.
REQ-007 SHALL have ports pc and pc_plus4, output, 32 bits each: the current fetch address and pc+4.
REQ-008 SHALL have ports branch_taken (input, 1 bit) and branch_offset (input, 32 bits), a sign-extended word offset.
REQ-009 SHALL have ports jump (input, 1 bit) and jump_index (input, 26 bits).
REQ-010 SHALL have ports jump_reg (input, 1 bit) and jr_target (input, 32 bits).
REQ-011 SHALL have ports halt and resume, input, 1 bit each.
REQ-012 SHALL have port state, output, 2 bits: IDLE=0, FETCH=1, HALTED=2.
REQ-013 SHALL have port retire_count, output, 32 bits: the number of accepted fetches.
REQ-014 SHALL have port misalign_trap, output, 1 bit.

Function
REQ-015 SHALL define accept as fetch_valid && fetch_ready; pc, retire_count and state change only on accept, except for the IDLE and HALTED transitions.
REQ-016 SHALL sequence IDLE for exactly one cycle after reset release, then enter FETCH unconditionally.
REQ-017 SHALL drive fetch_valid=1 only in FETCH, and SHALL hold pc stable while fetch_valid=1 and fetch_ready=0.
REQ-018 SHALL select next pc on accept with priority halt > jump_reg > jump > branch_taken > sequential.
REQ-019 SHALL compute the targets as follows:
- sequential = pc_plus4
- branch = pc_plus4 + (branch_offset<<2), mod 2^32
- jump = {pc_plus4[31:28], jump_index, 2'b00}
- jump_reg = jr_target
REQ-020 SHALL, on accept with halt=1, load pc_plus4 and enter HALTED; redirect inputs are ignored in that cycle.
REQ-021 SHALL, in HALTED with resume=1, enter FETCH on the next edge with pc unchanged; resume SHALL be ignored outside HALTED.
REQ-022 SHALL ignore all redirect inputs when there is no accept.
REQ-023 SHALL increment retire_count by 1 per accept, wrapping from 32'hFFFF_FFFF to 0.
REQ-024 SHALL wrap pc arithmetic mod 2^32, so pc 32'hFFFF_FFFC sequential gives 0.
REQ-025 SHALL drive pc_plus4 combinationally from pc.

Reset
REQ-026 SHALL, while rst=1, force the following regardless of clk:
- pc=RESET_VEC
- state=IDLE
- fetch_valid=0
- retire_count=0
- misalign_trap=0
REQ-027 SHALL, if rst asserts mid-handshake, abandon the pending fetch with no retire_count increment.

Configuration
REQ-028 SHALL, with PC_MISALIGN_TRAP_EN defined, check every accept with jump_reg=1 and jr_target[1:0]!=0:
- load pc=EXC_VEC
- pulse misalign_trap=1 for one cycle
- still increment retire_count
REQ-029 SHALL, without PC_MISALIGN_TRAP_EN, force jr_target[1:0] to 2'b00 on load and tie misalign_trap to 0.

Structure
REQ-030 SHALL place the state encoding and the default RESET_VEC/EXC_VEC constants in shared package mips_pkg.
REQ-031 SHALL instantiate the existing AddFour block as its single sub-module to produce pc_plus4.

Verification
REQ-032 SHALL cover reset and sequential run: release rst, fetch_ready=1 for 4 cycles -> pc 0,4,8,12; retire_count=3 after the 4th cycle; fetch_valid=0 in IDLE.
REQ-033 SHALL cover backpressure: pc=8, fetch_ready=0 for 3 cycles with branch_taken=1 -> pc stays 8 and retire_count is unchanged.
REQ-034 SHALL cover redirect priority: pc=32'h0000_1000, accept with jump=1, jump_index=26'h40, branch_taken=1, branch_offset=-1 -> pc=32'h0000_0100; repeat with branch only -> pc=32'h0000_1000.
REQ-035 SHALL cover halt/resume: accept with halt=1 at pc=0x20 -> state=HALTED and pc=0x24; resume pulse -> FETCH with pc=0x24.
REQ-036 SHALL cover misaligned jr: accept with jump_reg=1, jr_target=32'h0000_0102 -> pc=0x180 and a one-cycle misalign_trap with the macro; pc=0x100 and misalign_trap=0 without it.
REQ-037 SHALL cover wrap: pc=32'hFFFF_FFFC, accept -> pc=0; retire_count preset 32'hFFFF_FFFF -> 0.
